// File: rtl/rr_stream_pkg.sv
// rr_stream_pkg: shared arbitration modes and index-width helper
package rr_stream_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: round-robin or fixed-priority grant with an owned rotation pointer
module rr_arbiter import rr_stream_pkg::*; #(
  parameter int N = 8,
  parameter int MODE = MODE_RR,
  parameter int SEL_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W:0] j;
  always_comb begin
    grant_idx = '0;
    grant_valid = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = (MODE == MODE_FIXED ? '0 : {1'b0, ptr_q}) + (SEL_W+1)'(k);
      j = (j >= (SEL_W+1)'(N)) ? j - (SEL_W+1)'(N) : j;
      if (!grant_valid && req[j[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx = j[SEL_W-1:0];
      end
    end
  end
  assign grant_onehot = {{(N-1){1'b0}}, grant_valid} << grant_idx;
  always_comb begin
    ptr_d = ptr_q;
    if (MODE == MODE_RR && advance)
      ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
  end
  always_ff @(posedge clk) begin
    ptr_q <= rst ? '0 : ptr_d;
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel arbitrated stream mux with registered output and grant index
module rr_stream_mux import rr_stream_pkg::*; #(
  parameter int N = 8,
  parameter int WIDTH = 8,
  parameter int MODE = MODE_RR,
  parameter int SEL_W = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);
  logic load, accept, grant_valid;
  logic [N-1:0] grant_onehot;
  logic [SEL_W-1:0] grant_idx;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  rr_arbiter #(.N(N), .MODE(MODE), .SEL_W(SEL_W)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(in_valid),
    .advance(accept),
    .grant_onehot(grant_onehot),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid)
  );
  assign load = !out_valid_q || out_ready;
  assign accept = load && grant_valid && !rst;
  assign in_ready = accept ? grant_onehot : '0;
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d = accept ? in_data[grant_idx*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = accept ? grant_idx : out_sel_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule
